// File: rtl/tempsens_sequencer.sv
// Measurement sequencer for the ring-oscillator temperature sensor: gated count
// windows, 2^LOG2_AVG averaging, and two-byte UART streaming of the result.
module tempsens_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned WINDOW_CYCLES  = 1000,
  parameter int unsigned LOG2_AVG       = 3,
  parameter int unsigned HOLDOFF_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] count,
  input  logic             tx_busy,
  output logic             osc_en,
  output logic             cnt_clear,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int unsigned ACC_W  = WIDTH + LOG2_AVG;
  localparam int unsigned WCNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned HCNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [4:0]        KLAST = 5'((1 << LOG2_AVG) - 1);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HLAST = HCNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, GATE, LATCH, DONE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, HOLDOFF
  } state_t;

  state_t             state;
  logic [4:0]         k;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [WCNT_W-1:0]  wcnt;
  logic [HCNT_W-1:0]  hcnt;
  logic [2:0]         tcnt;
  logic               seen;
  logic               byte_done;
  logic [15:0]        res16;

  generate
    if (WIDTH >= 16) begin : g_res_trunc
      always_comb res16 = result[15:0];
    end else begin : g_res_pad
      always_comb res16 = {{(16 - WIDTH){1'b0}}, result};
    end
  endgenerate

  always_comb begin
    sum = acc + ACC_W'(count);
    // A byte is finished once the UART has been seen busy and released, or
    // if it never signalled busy within four cycles of tx_start.
    byte_done = !tx_busy && (seen || tcnt == 3'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      acc          <= '0;
      wcnt         <= '0;
      hcnt         <= '0;
      tcnt         <= '0;
      seen         <= 1'b0;
      osc_en       <= 1'b0;
      cnt_clear    <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt_clear    <= 1'b0;
      tx_start     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          k   <= '0;
          acc <= '0;
          if (start || auto_en) begin
            state     <= CLEAR;
            cnt_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          osc_en <= 1'b1;
          wcnt   <= '0;
          state  <= GATE;
        end
        GATE: begin
          if (wcnt == WLAST) begin
            osc_en <= 1'b0;
            state  <= LATCH;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        LATCH: begin
          acc <= sum;
          // The average is registered here so result and result_valid are
          // both visible during the DONE cycle.
          if (k == KLAST) begin
            result       <= WIDTH'(sum >> LOG2_AVG);
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            k         <= k + 1'b1;
            cnt_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        DONE: begin
          k     <= '0;
          acc   <= '0;
          state <= SEND_LO;
        end
        SEND_LO: begin
          if (!tx_busy) begin
            tx_data  <= res16[7:0];
            tx_start <= 1'b1;
            tcnt     <= '0;
            seen     <= 1'b0;
            state    <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (byte_done) begin
            state <= SEND_HI;
          end else begin
            if (tx_busy) seen <= 1'b1;
            tcnt <= tcnt + 1'b1;
          end
        end
        SEND_HI: begin
          if (!tx_busy) begin
            tx_data  <= res16[15:8];
            tx_start <= 1'b1;
            tcnt     <= '0;
            seen     <= 1'b0;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (byte_done) begin
            if (auto_en) begin
              hcnt  <= '0;
              state <= HOLDOFF;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            if (tx_busy) seen <= 1'b1;
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (!auto_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (hcnt == HLAST) begin
            cnt_clear <= 1'b1;
            state     <= CLEAR;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
